montgomery_param: RTL

Parametrised bit-serial radix-2 Montgomery multiplier. It computes result = a·b·2^-WIDTH mod m for odd m, with operand width set at elaboration. It is the successor of the fixed 381-bit montgomery core and sits under the ECDSA-verify field arithmetic unit. Over the fixed core it adds:

- a busy indication;
- a defined rule for start while busy;
- guaranteed fully reduced output;
- optional operand checking.

---
 rtl/montgomery_param.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/montgomery_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m (m odd).
// Ports: clk, reset (sync, active-high), start, in_a/in_b/in_m (WIDTH),
//        result (WIDTH), done (1-cycle pulse), busy, error.
// Optional operand check compiled in with `define MONT_OPERAND_CHECK_EN.
module montgomery_param #(
    parameter int WIDTH = 381
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] ILAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        SUB,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH+1:0] c_q, c_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;
    logic             c_ge_m;
    logic [WIDTH-1:0] c_sub;
    logic             bad;

    // C < 2M and B < M keep T < 4M, so WIDTH+2 bits never overflow.
    assign m_ext  = {2'b00, m_q};
    assign t_add  = c_q + (a_q[i_q] ? {2'b00, b_q} : '0);
    assign t_red  = t_add + (t_add[0] ? m_ext : '0);
    assign c_ge_m = (c_q >= m_ext);
    // C - M < M < 2^WIDTH, so the low WIDTH bits carry the full difference.
    assign c_sub  = c_q[WIDTH-1:0] - m_q;

`ifdef MONT_OPERAND_CHECK_EN
    assign bad = (in_a >= in_m) | (in_b >= in_m) | ~in_m[0];
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        i_d      = i_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        error_d  = error_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    c_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    error_d = bad;
                    if (bad) begin
                        // Rejected operands skip straight to the done cycle.
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = LOOP;
                    end
                end
            end
            LOOP: begin
                c_d = t_red >> 1;
                i_d = i_q + 1'b1;
                if (i_q == ILAST) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                result_d = c_ge_m ? c_sub : c_q[WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            c_q      <= c_d;
            i_q      <= i_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign error  = error_q;

endmodule
